// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the RAM copy/fill engine.
// Contents: RAM geometry (ADDR_W, DATA_W, LEN_W, MEM_DEPTH), the FSM state encoding,
// the transfer mode encoding and a length range check used when a request is accepted.
package mem_copy_engine_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 8;
    localparam int LEN_W     = 11;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_t;

    // A request may cover at most the whole RAM once.
    function automatic logic len_valid(input logic [LEN_W-1:0] len);
        return len <= LEN_W'(MEM_DEPTH);
    endfunction

endpackage

// File: rtl/mem_copy_engine_if.sv
// Bundle of request, status and RAM pin signals for the copy/fill engine.
// master: engine side (takes the request and RAM read data, drives status and RAM pins).
// slave : controller/RAM side (drives the request and RAM read data, observes the rest).
//   start/mode/src_addr/dst_addr/length/fill_data : request, sampled with start in IDLE
//   busy/done/error                                : status (done/error are 1-cycle pulses)
//   mem_enable/mem_read_write/mem_address/mem_data_in : registered RAM pins (rw 1 = read)
//   mem_data_out                                   : combinational RAM read data
interface mem_copy_engine_if;
    import mem_copy_engine_pkg::*;

    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] fill_data;
    logic              busy;
    logic              done;
    logic              error;
    logic              mem_enable;
    logic              mem_read_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        input  start, mode, src_addr, dst_addr, length, fill_data, mem_data_out,
        output busy, done, error, mem_enable, mem_read_write, mem_address, mem_data_in
    );

    modport slave (
        output start, mode, src_addr, dst_addr, length, fill_data, mem_data_out,
        input  busy, done, error, mem_enable, mem_read_write, mem_address, mem_data_in
    );

endinterface

// File: rtl/copy_addr_gen.sv
// Byte index and address generator for the copy/fill engine.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (clears the index)
//   load              : latch bases and length, restart index at 0
//   inc               : advance index by one
//   src_base/dst_base : source / destination base addresses
//   length            : byte count of the transfer
//   src_cur/dst_cur   : base + index, wrapping modulo RAM depth
//   last              : current index is the final byte (index == length - 1)
module copy_addr_gen
    import mem_copy_engine_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [LEN_W-1:0]  length,
    output logic [ADDR_W-1:0] src_cur,
    output logic [ADDR_W-1:0] dst_cur,
    output logic              last
);

    logic [LEN_W-1:0]  idx_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if (load) begin
            idx_q <= '0;
        end else if (inc) begin
            idx_q <= idx_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            src_q <= src_base;
            dst_q <= dst_base;
            len_q <= length;
        end
    end

    // Dropping the index MSB gives the modulo-depth wrap for free.
    assign src_cur = src_q + idx_q[ADDR_W-1:0];
    assign dst_cur = dst_q + idx_q[ADDR_W-1:0];
    assign last    = (idx_q == len_q - LEN_W'(1));

endmodule

// File: rtl/mem_copy_engine.sv
// Bus initiator for an asynchronous 8x1024 RAM: block COPY (RAM->RAM) or block FILL
// (constant) of up to 1024 bytes, one Start request at a time.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : mem_copy_engine_if.master (request inputs, status outputs, RAM pins)
// Every output is a flop; the next value is computed together with the next state.
// Each byte is RD (copy only), WR, GAP; GAP drops Enable while Address/DataIn hold,
// so the level-sensitive RAM write never sees those pins move.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    mem_copy_engine_if.master         bus
);

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              en_q, en_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Doubles as the capture register: in COPY it takes the RAM read data at the end of RD.
    logic [DATA_W-1:0] din_q, din_d;

    mode_t             mode_q;
    logic [DATA_W-1:0] fill_q;
    logic              last_q;

    logic              load;
    logic              inc;
    logic [ADDR_W-1:0] src_cur;
    logic [ADDR_W-1:0] dst_cur;
    logic              last;

    copy_addr_gen u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .inc      (inc),
        .src_base (bus.src_addr),
        .dst_base (bus.dst_addr),
        .length   (bus.length),
        .src_cur  (src_cur),
        .dst_cur  (dst_cur),
        .last     (last)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;
        en_d    = 1'b0;
        rw_d    = 1'b1;
        addr_d  = addr_q;
        din_d   = din_q;
        load    = 1'b0;
        inc     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (!len_valid(bus.length)) begin
                        error_d = 1'b1;
                    end else if (bus.length == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        load   = 1'b1;
                        busy_d = 1'b1;
                        en_d   = 1'b1;
                        // Index is 0 here, so the raw bases are the first addresses.
                        if (mode_t'(bus.mode) == MODE_COPY) begin
                            state_d = ST_RD;
                            addr_d  = bus.src_addr;
                        end else begin
                            state_d = ST_WR;
                            rw_d    = 1'b0;
                            addr_d  = bus.dst_addr;
                            din_d   = bus.fill_data;
                        end
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WR;
                busy_d  = 1'b1;
                en_d    = 1'b1;
                rw_d    = 1'b0;
                addr_d  = dst_cur;
                din_d   = bus.mem_data_out;
            end
            ST_WR: begin
                // Index advances here; GAP drives from the held address flops,
                // so the incremented index is ready for the next RD/WR.
                state_d = ST_GAP;
                busy_d  = 1'b1;
                inc     = 1'b1;
            end
            ST_GAP: begin
                if (last_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    en_d   = 1'b1;
                    if (mode_q == MODE_COPY) begin
                        state_d = ST_RD;
                        addr_d  = src_cur;
                    end else begin
                        state_d = ST_WR;
                        rw_d    = 1'b0;
                        addr_d  = dst_cur;
                        din_d   = fill_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            en_q    <= 1'b0;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            // Remember whether the byte just written was the final one.
            if (inc) begin
                last_q <= last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            mode_q <= mode_t'(bus.mode);
            fill_q <= bus.fill_data;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;
    assign bus.mem_enable     = en_q;
    assign bus.mem_read_write = rw_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_data_in    = din_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural 1024x8 RAM attached.
module tb_mem_copy_engine;
    import mem_copy_engine_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_copy_engine_if bus ();

    mem_copy_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write applied mid-cycle while enabled for write.
    logic [7:0] mem [1024];
    logic       mem_init;
    logic       poke_en;
    logic [9:0] poke_addr;
    logic [7:0] poke_data;

    function automatic logic [7:0] pat(input logic [9:0] a);
        return a[7:0] ^ 8'hC3;
    endfunction

    assign bus.mem_data_out = bus.mem_enable ? mem[bus.mem_address] : 8'h00;

    always @(negedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < 1024; a++) mem[a] <= pat(10'(a));
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (bus.mem_enable && !bus.mem_read_write) begin
            mem[bus.mem_address] <= bus.mem_data_in;
        end
    end

    // Address/data must hold from a write cycle into the following cycle.
    logic       prev_wr;
    logic [9:0] prev_addr;
    logic [7:0] prev_din;
    initial prev_wr = 1'b0;
    always @(negedge clk) begin
        if (prev_wr && !rst) begin
            checks++;
            assert (bus.mem_address === prev_addr && bus.mem_data_in === prev_din)
            else begin
                errors++;
                $error("FAIL wr_hold addr %0h din %0h expected addr %0h din %0h",
                       bus.mem_address, bus.mem_data_in, prev_addr, prev_din);
            end
        end
        prev_wr   <= bus.mem_enable && !bus.mem_read_write;
        prev_addr <= bus.mem_address;
        prev_din  <= bus.mem_data_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        tick();
        poke_en   = 1'b0;
    endtask

    // Issue one request and watch it; cycle 1 is the first cycle after the sampling edge.
    task automatic run(input logic m, input logic [9:0] s, input logic [9:0] d,
                       input logic [10:0] n, input logic [7:0] f, input int budget,
                       output int done_c, output int busy_c, output int en_c,
                       output int err_c, output int err_n);
        int c;
        done_c = 0; busy_c = 0; en_c = 0; err_c = 0; err_n = 0;
        bus.mode = m; bus.src_addr = s; bus.dst_addr = d; bus.length = n; bus.fill_data = f;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 1;
        while (c <= budget && done_c == 0) begin
            if (bus.busy) busy_c++;
            if (bus.mem_enable) en_c++;
            if (bus.error) begin
                err_n++;
                if (err_c == 0) err_c = c;
            end
            if (bus.done) done_c = c;
            else begin
                tick();
                c++;
            end
        end
    endtask

    initial begin
        int done_c, busy_c, en_c, err_c, err_n;
        checks = 0; errors = 0;
        rst = 1'b1; mem_init = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
        bus.length = '0; bus.fill_data = '0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_en", 32'(bus.mem_enable), 32'd0);
        check("rst_rw", 32'(bus.mem_read_write), 32'd1);
        check("rst_addr", 32'(bus.mem_address), 32'd0);
        check("rst_din", 32'(bus.mem_data_in), 32'd0);
        mem_init = 1'b1;
        tick();
        mem_init = 1'b0;
        rst = 1'b0;
        tick();

        // 1: FILL 0..3 with 5A
        run(1'b1, 10'd0, 10'd0, 11'd4, 8'h5A, 20, done_c, busy_c, en_c, err_c, err_n);
        check("fill_done_cyc", 32'(done_c), 32'd9);
        check("fill_busy_cnt", 32'(busy_c), 32'd8);
        check("fill_busy_at_done", 32'(bus.busy), 32'd0);
        tick();
        check("fill_done_pulse", 32'(bus.done), 32'd0);
        for (int a = 0; a < 4; a++) check("fill_mem", 32'(mem[a]), 32'h5A);
        check("fill_mem4", 32'(mem[4]), 32'hC7);

        // 2: COPY 0..3 -> 100..103
        poke(10'd0, 8'hAA); poke(10'd1, 8'h0A); poke(10'd2, 8'h0B); poke(10'd3, 8'h0C);
        run(1'b0, 10'd0, 10'd100, 11'd4, 8'h00, 30, done_c, busy_c, en_c, err_c, err_n);
        check("copy_done_cyc", 32'(done_c), 32'd13);
        tick();
        check("copy_mem100", 32'(mem[100]), 32'hAA);
        check("copy_mem101", 32'(mem[101]), 32'h0A);
        check("copy_mem102", 32'(mem[102]), 32'h0B);
        check("copy_mem103", 32'(mem[103]), 32'h0C);

        // 3: FILL across the top of the address space
        run(1'b1, 10'd0, 10'd1022, 11'd4, 8'hFF, 20, done_c, busy_c, en_c, err_c, err_n);
        check("wrap_done_cyc", 32'(done_c), 32'd9);
        tick();
        check("wrap_mem1022", 32'(mem[1022]), 32'hFF);
        check("wrap_mem1023", 32'(mem[1023]), 32'hFF);
        check("wrap_mem0", 32'(mem[0]), 32'hFF);
        check("wrap_mem1", 32'(mem[1]), 32'hFF);
        check("wrap_mem2", 32'(mem[2]), 32'h0B);

        // 4: zero length and oversize length
        run(1'b0, 10'd0, 10'd50, 11'd0, 8'h00, 5, done_c, busy_c, en_c, err_c, err_n);
        check("len0_done_cyc", 32'(done_c), 32'd1);
        check("len0_en_cnt", 32'(en_c), 32'd0);
        check("len0_busy_cnt", 32'(busy_c), 32'd0);
        tick();
        run(1'b0, 10'd0, 10'd50, 11'd1025, 8'h00, 6, done_c, busy_c, en_c, err_c, err_n);
        check("big_err_cyc", 32'(err_c), 32'd1);
        check("big_err_cnt", 32'(err_n), 32'd1);
        check("big_done", 32'(done_c), 32'd0);
        check("big_en_cnt", 32'(en_c), 32'd0);
        check("big_busy_cnt", 32'(busy_c), 32'd0);

        // 5: restart ignored while busy, then reset after two bytes
        poke(10'd0, 8'h12); poke(10'd1, 8'h34);
        bus.mode = 1'b0; bus.src_addr = 10'd0; bus.dst_addr = 10'd300;
        bus.length = 11'd4; bus.fill_data = 8'h00;
        bus.start = 1'b1;
        tick();                                   // cycle 1: RD byte 0
        bus.start = 1'b0;
        check("abort_busy_c1", 32'(bus.busy), 32'd1);
        tick();                                   // cycle 2: WR byte 0
        bus.mode = 1'b1; bus.dst_addr = 10'd500; bus.length = 11'd1; bus.fill_data = 8'h99;
        bus.start = 1'b1;
        tick();                                   // cycle 3: GAP
        bus.start = 1'b0;
        check("ignore_err", 32'(bus.error), 32'd0);
        tick(); tick(); tick();                   // cycle 6: GAP after byte 1
        tick();                                   // cycle 7: RD byte 2
        check("abort_rd_addr", 32'(bus.mem_address), 32'd2);
        rst = 1'b1;
        tick();
        check("abort_en", 32'(bus.mem_enable), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        tick();
        check("abort_done_after", 32'(bus.done), 32'd0);
        tick();
        check("abort_mem300", 32'(mem[300]), 32'h12);
        check("abort_mem301", 32'(mem[301]), 32'h34);
        check("abort_mem302", 32'(mem[302]), 32'hED);
        check("abort_mem303", 32'(mem[303]), 32'hEC);
        check("ignore_mem500", 32'(mem[500]), 32'h37);

        // 6: overlapping ascending copy replicates the first byte
        poke(10'd0, 8'h11); poke(10'd1, 8'h22); poke(10'd2, 8'h33); poke(10'd3, 8'h44);
        run(1'b0, 10'd0, 10'd1, 11'd3, 8'h00, 20, done_c, busy_c, en_c, err_c, err_n);
        check("ovl_done_cyc", 32'(done_c), 32'd10);
        tick();
        check("ovl_mem0", 32'(mem[0]), 32'h11);
        check("ovl_mem1", 32'(mem[1]), 32'h11);
        check("ovl_mem2", 32'(mem[2]), 32'h11);
        check("ovl_mem3", 32'(mem[3]), 32'h11);
        check("ovl_mem4", 32'(mem[4]), 32'hC7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
